// File: rtl/fsm_seq_ctrl_pkg.sv
// Shared types for the state-code sequencer: control-state encoding, direction
// constants and the one-step advance rule used by both auto-advance and single-step.
package fsm_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ctrl_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int CODE_W = 3;
  typedef logic [CODE_W-1:0] code_t;

  typedef struct packed {
    logic  wrap;
    code_t code;
  } adv_t;

  function automatic adv_t advance(input code_t code, input logic dir, input code_t last);
    adv_t r;
    r.wrap = 1'b0;
    r.code = code;
    if (dir == DIR_UP) begin
      if (code == last) begin
        r.code = '0;
        r.wrap = 1'b1;
      end else begin
        r.code = code + code_t'(1);
      end
    end else if (dir == DIR_DN) begin
      if (code == '0) begin
        r.code = last;
        r.wrap = 1'b1;
      end else begin
        r.code = code - code_t'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fsm_seq_ctrl_if.sv
// Button-side controls and decoder-side state code of the sequencer.
// master drives the buttons and observes the code; slave is the sequencer.
interface fsm_seq_ctrl_if;
  logic start;
  logic stop;
  logic step;
  logic dir;
  logic ea0;
  logic ea1;
  logic ea2;
  logic running;
  logic wrap;

  modport master (
    output start, stop, step, dir,
    input  ea0, ea1, ea2, running, wrap
  );

  modport slave (
    input  start, stop, step, dir,
    output ea0, ea1, ea2, running, wrap
  );
endinterface

// File: rtl/fsm_seq_ctrl_seq_tick_gen.sv
// Prescaler: tick is high combinationally in the cycle the count reaches TICK_DIV-1,
// then the count wraps to 0; clr has priority and holds the count at 0, en=0 freezes it.
module seq_tick_gen #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// IDLE/RUN/PAUSE sequencer producing the 3-bit code for the 7-segment decoder.
// Button edges act in the cycle they are seen; code, running and wrap change one cycle later.
module fsm_seq_ctrl
  import fsm_seq_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int LAST_STATE = 7,
  parameter int CNT_W      = $clog2(TICK_DIV)
) (
  input  logic           clk,
  input  logic           rst,
  fsm_seq_ctrl_if.slave  bus
);

  localparam code_t LAST = code_t'(LAST_STATE);

  ctrl_state_t state, state_nxt;
  code_t       code, code_nxt;
  logic        wrap_q, wrap_nxt;
  logic        run_q;
  logic        start_q, stop_q, step_q;
  logic        start_e, stop_e, step_e;
  logic        tick;
  adv_t        adv;

  // History resets high: a button already held when reset drops is a level, not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      step_q  <= 1'b1;
    end else begin
      start_q <= bus.start;
      stop_q  <= bus.stop;
      step_q  <= bus.step;
    end
  end

  assign start_e = bus.start & ~start_q;
  assign stop_e  = bus.stop  & ~stop_q;
  assign step_e  = bus.step  & ~step_q;

  // Clearing outside RUN makes every resume start a full prescaler period.
  seq_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   ((state == RUN) && !stop_e),
    .clr  (state != RUN),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      code   <= '0;
      wrap_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      code   <= code_nxt;
      wrap_q <= wrap_nxt;
      run_q  <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    wrap_nxt  = 1'b0;
    adv       = advance(code, bus.dir, LAST);
    unique case (state)
      IDLE: begin
        code_nxt = '0;
        if (start_e) state_nxt = RUN;
      end
      RUN: begin
        if (stop_e) begin
          state_nxt = PAUSE;
        end else if (tick) begin
          code_nxt = adv.code;
          wrap_nxt = adv.wrap;
        end
      end
      PAUSE: begin
        if (stop_e) begin
          state_nxt = IDLE;
          code_nxt  = '0;
        end else if (start_e) begin
          state_nxt = RUN;
        end else if (step_e) begin
          code_nxt = adv.code;
          wrap_nxt = adv.wrap;
        end
      end
      default: begin
        state_nxt = IDLE;
        code_nxt  = '0;
      end
    endcase
  end

  assign bus.ea0     = code[0];
  assign bus.ea1     = code[1];
  assign bus.ea2     = code[2];
  assign bus.running = run_q;
  assign bus.wrap    = wrap_q;

endmodule
